// File: rtl/zsw_debounce.sv
// Push-button debouncer: 2-flop sync, STABLE_CYCLES qualify window, single-cycle press/release events.
// Pulses and level register STABLE_CYCLES+2 edges after the pad settles; no backpressure; ZSW_LONGPRESS_EN adds oSwLong.
module zsw_debounce #(
  parameter int STABLE_CYCLES = 500000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iSwRaw,
  output logic oSwLevel,
  output logic oSwDown,
  output logic oSwUp,
  output logic oSwLong
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic PAD_IDLE = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} stateT;

  logic syncMeta, syncPad, swSync;
  stateT state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic levelNxt, downNxt, upNxt;

  // Reset to the idle pad level so reset itself never looks like an edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      syncMeta <= PAD_IDLE;
      syncPad  <= PAD_IDLE;
    end else begin
      syncMeta <= iSwRaw;
      syncPad  <= syncMeta;
    end
  end

  assign swSync = (ACTIVE_LOW != 0) ? ~syncPad : syncPad;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= RELEASED;
      cnt      <= '0;
      oSwLevel <= 1'b0;
      oSwDown  <= 1'b0;
      oSwUp    <= 1'b0;
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      oSwLevel <= levelNxt;
      oSwDown  <= downNxt;
      oSwUp    <= upNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    levelNxt = oSwLevel;
    downNxt  = 1'b0;
    upNxt    = 1'b0;
    case (state)
      RELEASED: begin
        if (swSync) begin
          stateNxt = PRESS_WAIT;
          cntNxt   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!swSync) begin
          stateNxt = RELEASED;
          cntNxt   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNxt = PRESSED;
          cntNxt   = '0;
          levelNxt = 1'b1;
          downNxt  = 1'b1;
        end else begin
          cntNxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!swSync) begin
          stateNxt = RELEASE_WAIT;
          cntNxt   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (swSync) begin
          stateNxt = PRESSED;
          cntNxt   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNxt = RELEASED;
          cntNxt   = '0;
          levelNxt = 1'b0;
          upNxt    = 1'b1;
        end else begin
          cntNxt = cnt + CW'(1);
        end
      end
      default: begin
        stateNxt = RELEASED;
        cntNxt   = '0;
      end
    endcase
  end

`ifdef ZSW_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES) + 1;
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

  logic [LW-1:0] longCnt, longCntNxt;
  logic longNxt;

  // Keeps counting through RELEASE_WAIT so a release bounce does not restart the hold time.
  always_comb begin
    longCntNxt = '0;
    longNxt    = 1'b0;
    if (state == PRESSED || state == RELEASE_WAIT) begin
      longCntNxt = (longCnt == LONG_SAT) ? longCnt : longCnt + LW'(1);
      longNxt    = (longCnt == LONG_LAST);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      longCnt <= '0;
      oSwLong <= 1'b0;
    end else begin
      longCnt <= longCntNxt;
      oSwLong <= longNxt;
    end
  end
`else
  assign oSwLong = 1'b0;
`endif

endmodule

// File: tb/tb_zsw_debounce.sv
// Bench for zsw_debounce: directed scenarios plus random pad activity against a run-length reference model.
module tb_zsw_debounce;
  localparam int STABLE = 4;
  localparam int LONG   = 16;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic iSwRaw = 1'b1;
  logic oSwLevel, oSwDown, oSwUp, oSwLong;

  always #5 iClk = ~iClk;

  zsw_debounce #(.STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)) dut (
    .iClk(iClk), .iRst(iRst), .iSwRaw(iSwRaw),
    .oSwLevel(oSwLevel), .oSwDown(oSwDown), .oSwUp(oSwUp), .oSwLong(oSwLong)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference: pad delayed two samples, then a level flips once it disagrees for STABLE samples in a row.
  logic pipe[$];
  logic mLevel = 1'b0;
  int   run = 0;
  int   held = 0;
  logic eDown = 1'b0, eUp = 1'b0, eLong = 1'b0;

  int downCnt = 0, upCnt = 0, longCnt = 0;
  int lastDown = -1, lastUp = -1, lastLong = -1;

  task automatic cycle(input logic raw, input logic rst);
    logic sFsm;
    iSwRaw = raw;
    iRst   = rst;
    @(posedge iClk);
    cyc++;
    eDown = 1'b0;
    eUp   = 1'b0;
    eLong = 1'b0;
    if (rst) begin
      pipe   = '{1'b1, 1'b1};
      mLevel = 1'b0;
      run    = 0;
      held   = 0;
    end else begin
      sFsm = ~pipe.pop_front();
      pipe.push_back(raw);
      if (mLevel) begin
        held++;
`ifdef ZSW_LONGPRESS_EN
        eLong = (held == LONG);
`endif
      end else begin
        held = 0;
      end
      if (sFsm != mLevel) begin
        run++;
        if (run == STABLE) begin
          mLevel = sFsm;
          run    = 0;
          eDown  = sFsm;
          eUp    = ~sFsm;
        end
      end else begin
        run = 0;
      end
    end
    #1;
    vectors++;
    assert (oSwLevel === mLevel) else begin
      miscompares++; $error("FAIL level cyc=%0d got=%b exp=%b", cyc, oSwLevel, mLevel);
    end
    assert (oSwDown === eDown) else begin
      miscompares++; $error("FAIL down cyc=%0d got=%b exp=%b", cyc, oSwDown, eDown);
    end
    assert (oSwUp === eUp) else begin
      miscompares++; $error("FAIL up cyc=%0d got=%b exp=%b", cyc, oSwUp, eUp);
    end
    assert (oSwLong === eLong) else begin
      miscompares++; $error("FAIL long cyc=%0d got=%b exp=%b", cyc, oSwLong, eLong);
    end
    assert (!(oSwDown === 1'b1 && oSwUp === 1'b1)) else begin
      miscompares++; $error("FAIL exclusive cyc=%0d down=%b up=%b exp=not both", cyc, oSwDown, oSwUp);
    end
    if (oSwDown === 1'b1) begin downCnt++; lastDown = cyc; end
    if (oSwUp === 1'b1)   begin upCnt++;   lastUp   = cyc; end
    if (oSwLong === 1'b1) begin longCnt++; lastLong = cyc; end
  endtask

  initial begin
    int e0, d0, u0, l0, len;
    logic lvl, rst;

    pipe = '{1'b1, 1'b1};

    // Reset state and idle.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    vectors++;
    assert (downCnt == 0 && upCnt == 0 && longCnt == 0 && oSwLevel === 1'b0) else begin
      miscompares++; $error("FAIL idle events down=%0d up=%0d long=%0d level=%b exp=0", downCnt, upCnt, longCnt, oSwLevel);
    end

    // Bounce then stable press.
    d0 = downCnt;
    for (int i = 0; i < 12; i++) cycle(((i / 2) % 2) == 1, 1'b0);
    vectors++;
    assert (downCnt == d0) else begin
      miscompares++; $error("FAIL bounce_nodown got=%0d exp=%0d", downCnt, d0);
    end
    e0 = cyc + 1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    vectors++;
    assert (downCnt - d0 == 1 && lastDown == e0 + STABLE + 1) else begin
      miscompares++; $error("FAIL press_latency count=%0d at=%0d exp count=1 at=%0d", downCnt - d0, lastDown, e0 + STABLE + 1);
    end

    // Release with a one-sample glitch inside the window.
    u0 = upCnt;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    e0 = cyc + 1;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
    vectors++;
    assert (upCnt - u0 == 1 && lastUp == e0 + STABLE + 1) else begin
      miscompares++; $error("FAIL release_latency count=%0d at=%0d exp count=1 at=%0d", upCnt - u0, lastUp, e0 + STABLE + 1);
    end

    // Glitch one sample short of the window.
    d0 = downCnt;
    for (int i = 0; i < STABLE - 1; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
    vectors++;
    assert (downCnt == d0 && oSwLevel === 1'b0) else begin
      miscompares++; $error("FAIL short_glitch downs=%0d level=%b exp downs=%0d level=0", downCnt, oSwLevel, d0);
    end

    // Long hold.
    l0 = longCnt;
    for (int i = 0; i < STABLE + 2 + 30; i++) cycle(1'b0, 1'b0);
`ifdef ZSW_LONGPRESS_EN
    vectors++;
    assert (longCnt - l0 == 1 && lastLong == lastDown + LONG) else begin
      miscompares++; $error("FAIL long_press count=%0d at=%0d exp count=1 at=%0d", longCnt - l0, lastLong, lastDown + LONG);
    end
`else
    vectors++;
    assert (longCnt == l0) else begin
      miscompares++; $error("FAIL long_disabled count=%0d exp=%0d", longCnt, l0);
    end
`endif
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);

    // Reset in the middle of a press qualification.
    d0 = downCnt;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    vectors++;
    assert (downCnt == d0) else begin
      miscompares++; $error("FAIL reset_mid_nodown got=%0d exp=%0d", downCnt, d0);
    end
    e0 = cyc + 1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    vectors++;
    assert (downCnt - d0 == 1 && lastDown == e0 + STABLE + 1) else begin
      miscompares++; $error("FAIL reset_mid_press count=%0d at=%0d exp count=1 at=%0d", downCnt - d0, lastDown, e0 + STABLE + 1);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);

    // Random pad activity with occasional resets.
    while (cyc < 3000) begin
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(STABLE, 40) : $urandom_range(1, STABLE + 2));
      for (int i = 0; i < len; i++) begin
        rst = ($urandom_range(0, 99) == 0);
        cycle(lvl, rst);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
